// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the registered priority interrupt controller
package irq_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    // Index width for n items, never below one bit so degenerate sizes still have a port
    function automatic int bw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Position of bus b, channel c inside the flat request/pending vectors
    function automatic int flat_idx(input int b, input int c, input int nch);
        return b * nch + c;
    endfunction

endpackage

// File: rtl/irq_priority_ctrl_if.sv
// irq_priority_ctrl_if: request/grant bundle between peripherals, controller and service sequencer
interface irq_priority_ctrl_if #(
    parameter int NCH  = 9,
    parameter int NBUS = 3
);
    localparam int BW = irq_pkg::bw(NBUS);
    localparam int CW = irq_pkg::cw(NCH);

    logic [NBUS*NCH-1:0] req;
    logic [NBUS-1:0]     bus_en;
    logic                irq_ack;
    logic                irq_valid;
    logic [BW-1:0]       irq_bus;
    logic [CW-1:0]       irq_chan;
    logic [NBUS*NCH-1:0] pend;

    modport master (
        output req, bus_en, irq_ack,
        input  irq_valid, irq_bus, irq_chan, pend
    );

    modport slave (
        input  req, bus_en, irq_ack,
        output irq_valid, irq_bus, irq_chan, pend
    );

endinterface

// File: rtl/irq_prio_arb.sv
// irq_prio_arb: combinational find-first over the eligible vector, lowest bus then lowest channel
module irq_prio_arb
    import irq_pkg::*;
#(
    parameter  int NCH  = 9,
    parameter  int NBUS = 3,
    localparam int BW   = bw(NBUS),
    localparam int CW   = cw(NCH)
) (
    input  logic [NBUS*NCH-1:0] elig,
    output logic                any,
    output logic [BW-1:0]       bus_idx,
    output logic [CW-1:0]       chan_idx
);

    // Scan from the lowest priority upward so the last hit is the highest-priority winner
    always_comb begin
        any      = 1'b0;
        bus_idx  = '0;
        chan_idx = '0;
        for (int b = NBUS - 1; b >= 0; b--) begin
            for (int c = NCH - 1; c >= 0; c--) begin
                if (elig[flat_idx(b, c, NCH)]) begin
                    any      = 1'b1;
                    bus_idx  = BW'(b);
                    chan_idx = CW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: latches interrupt requests into pending bits and presents one winner per valid/ack handshake
module irq_priority_ctrl
    import irq_pkg::*;
#(
    parameter int NCH  = 9,
    parameter int NBUS = 3,
    parameter int EDGE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    irq_priority_ctrl_if.slave  bus
);

    localparam int N  = NBUS * NCH;
    localparam int BW = bw(NBUS);
    localparam int CW = cw(NCH);

    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  hist_q;
    logic [N-1:0]  set_v, clr_v, elig;
    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic [BW-1:0] bus_q, bus_d;
    logic [CW-1:0] chan_q, chan_d;
    logic          arb_any;
    logic [BW-1:0] arb_bus;
    logic [CW-1:0] arb_chan;
    logic          take, grab;

    assign take = (state_q == PRESENT) && bus.irq_ack;
    assign grab = (state_q == IDLE) && arb_any;

    // Capture new requests, retire the acknowledged bit; a simultaneous set keeps the bit pending
    always_comb begin
        set_v = (EDGE != 0) ? (bus.req & ~hist_q) : bus.req;
        clr_v = '0;
        elig  = '0;
        for (int b = 0; b < NBUS; b++) begin
            elig[b*NCH +: NCH] = pend_q[b*NCH +: NCH] & {NCH{bus.bus_en[b]}};
            for (int c = 0; c < NCH; c++) begin
                clr_v[flat_idx(b, c, NCH)] = take && (bus_q == BW'(b)) && (chan_q == CW'(c));
            end
        end
        pend_d = (pend_q & ~clr_v) | set_v;
    end

    irq_prio_arb #(
        .NCH  (NCH),
        .NBUS (NBUS)
    ) u_arb (
        .elig     (elig),
        .any      (arb_any),
        .bus_idx  (arb_bus),
        .chan_idx (arb_chan)
    );

    // Grant selection: latch a winner from IDLE, hold it unchanged until acknowledged
    always_comb begin
        state_d = (state_q == IDLE) ? (arb_any ? PRESENT : IDLE)
                                    : (bus.irq_ack ? IDLE : PRESENT);
        valid_d = (state_d == PRESENT);
        bus_d   = grab ? arb_bus : bus_q;
        chan_d  = grab ? arb_chan : chan_q;
    end

    // State, pending, request history and presented outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            bus_q   <= '0;
            chan_q  <= '0;
            pend_q  <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            bus_q   <= bus_d;
            chan_q  <= chan_d;
            pend_q  <= pend_d;
            hist_q  <= bus.req;
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_bus   = bus_q;
    assign bus.irq_chan  = chan_q;
    assign bus.pend      = pend_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: vector table, corner sequences and randomized model comparison
module tb_irq_priority_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_priority_ctrl_if #(.NCH(9), .NBUS(3)) ia ();
    irq_priority_ctrl_if #(.NCH(4), .NBUS(2)) ib ();

    irq_priority_ctrl #(.NCH(9), .NBUS(3), .EDGE(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    irq_priority_ctrl #(.NCH(4), .NBUS(2), .EDGE(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0] req;
        logic [2:0]  en;
        logic        ack;
        logic        valid;
        logic [1:0]  bus;
        logic [3:0]  chan;
        logic [26:0] pend;
    } vec_t;

    vec_t tv[30];

    bit [63:0] m_pend[2];
    bit [63:0] m_hist[2];
    bit        m_valid[2];
    int        m_bus[2];
    int        m_chan[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] bt(input int i);
        logic [26:0] one;
        one = 27'd1;
        return one << i;
    endfunction

    // Reference: pending set from the capture rule, winner = lowest flat index on an enabled bus
    task automatic model_step(input int k, input int nch, input int nbus, input bit edge_mode,
                              input bit [63:0] req, input bit [7:0] en, input bit ack);
        bit [63:0] nxt;
        bit        fire;
        int        presented;
        nxt = '0;
        fire = m_valid[k] && ack;
        presented = m_bus[k] * nch + m_chan[k];
        for (int i = 0; i < nch * nbus; i++) begin
            bit rise;
            rise = edge_mode ? (req[i] && !m_hist[k][i]) : req[i];
            nxt[i] = rise || (m_pend[k][i] && !(fire && i == presented));
        end
        if (m_valid[k]) begin
            if (ack) m_valid[k] = 1'b0;
        end else begin
            for (int i = 0; i < nch * nbus; i++) begin
                if (m_pend[k][i] && en[i / nch]) begin
                    m_valid[k] = 1'b1;
                    m_bus[k] = i / nch;
                    m_chan[k] = i % nch;
                    break;
                end
            end
        end
        m_pend[k] = nxt;
        m_hist[k] = req;
    endtask

    initial begin
        int grants;
        logic [26:0] p3;
        ia.req = '0; ia.bus_en = 3'b111; ia.irq_ack = 1'b0;
        ib.req = '0; ib.bus_en = 2'b11;  ib.irq_ack = 1'b0;
        p3 = bt(20) | bt(12) | bt(9);

        tv[0]  = '{bt(10), 3'b111, 1'b0, 1'b0, 2'd0, 4'd0, bt(10)};
        tv[1]  = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd1, 4'd1, bt(10)};
        tv[2]  = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[3]  = '{27'd0,  3'b111, 1'b0, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[4]  = '{p3,     3'b111, 1'b0, 1'b0, 2'd0, 4'd0, p3};
        tv[5]  = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd1, 4'd0, p3};
        tv[6]  = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, bt(20) | bt(12)};
        tv[7]  = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd1, 4'd3, bt(20) | bt(12)};
        tv[8]  = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, bt(20)};
        tv[9]  = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd2, 4'd2, bt(20)};
        tv[10] = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[11] = '{bt(2) | bt(25), 3'b110, 1'b0, 1'b0, 2'd0, 4'd0, bt(2) | bt(25)};
        tv[12] = '{27'd0,  3'b110, 1'b0, 1'b1, 2'd2, 4'd7, bt(2) | bt(25)};
        tv[13] = '{27'd0,  3'b110, 1'b1, 1'b0, 2'd0, 4'd0, bt(2)};
        tv[14] = '{27'd0,  3'b110, 1'b0, 1'b0, 2'd0, 4'd0, bt(2)};
        tv[15] = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd0, 4'd2, bt(2)};
        tv[16] = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[17] = '{bt(15), 3'b111, 1'b0, 1'b0, 2'd0, 4'd0, bt(15)};
        tv[18] = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd1, 4'd6, bt(15)};
        tv[19] = '{bt(0),  3'b101, 1'b0, 1'b1, 2'd1, 4'd6, bt(0) | bt(15)};
        tv[20] = '{27'd0,  3'b101, 1'b0, 1'b1, 2'd1, 4'd6, bt(0) | bt(15)};
        tv[21] = '{27'd0,  3'b101, 1'b1, 1'b0, 2'd0, 4'd0, bt(0)};
        tv[22] = '{27'd0,  3'b101, 1'b0, 1'b1, 2'd0, 4'd0, bt(0)};
        tv[23] = '{27'd0,  3'b101, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[24] = '{bt(3),  3'b111, 1'b0, 1'b0, 2'd0, 4'd0, bt(3)};
        tv[25] = '{bt(3),  3'b111, 1'b0, 1'b1, 2'd0, 4'd3, bt(3)};
        tv[26] = '{bt(3),  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, bt(3)};
        tv[27] = '{27'd0,  3'b111, 1'b0, 1'b1, 2'd0, 4'd3, bt(3)};
        tv[28] = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};
        tv[29] = '{27'd0,  3'b111, 1'b1, 1'b0, 2'd0, 4'd0, 27'd0};

        tick();
        tick();
        chk("reset_valid", ia.irq_valid, 0);
        chk("reset_bus", ia.irq_bus, 0);
        chk("reset_chan", ia.irq_chan, 0);
        chk("reset_pend", ia.pend, 0);
        chk("reset_pend_b", ib.pend, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            ia.req = tv[i].req;
            ia.bus_en = tv[i].en;
            ia.irq_ack = tv[i].ack;
            tick();
            chk($sformatf("vec%0d_valid", i), ia.irq_valid, tv[i].valid);
            chk($sformatf("vec%0d_pend", i), ia.pend, tv[i].pend);
            if (tv[i].valid) begin
                chk($sformatf("vec%0d_bus", i), ia.irq_bus, tv[i].bus);
                chk($sformatf("vec%0d_chan", i), ia.irq_chan, tv[i].chan);
            end
        end
        ia.req = '0; ia.irq_ack = 1'b0; ia.bus_en = 3'b111;

        grants = 0;
        ib.req = 8'h20;
        for (int i = 0; i < 10; i++) begin
            ib.irq_ack = ib.irq_valid;
            if (ib.irq_ack) grants++;
            tick();
        end
        ib.req = '0;
        for (int i = 0; i < 3; i++) begin
            ib.irq_ack = ib.irq_valid;
            if (ib.irq_ack) grants++;
            tick();
        end
        ib.irq_ack = 1'b0;
        chk("edge_hold_grants", grants, 1);
        chk("edge_hold_pend", ib.pend, 0);
        chk("edge_hold_valid", ib.irq_valid, 0);

        tick();
        ib.req = 8'h20;
        tick();
        chk("edge_rise_pend", ib.pend, 8'h20);
        ib.req = '0;
        tick();
        chk("edge_present_valid", ib.irq_valid, 1);
        chk("edge_present_bus", ib.irq_bus, 1);
        chk("edge_present_chan", ib.irq_chan, 1);
        ib.req = 8'h20;
        ib.irq_ack = 1'b1;
        tick();
        chk("edge_setwins_pend", ib.pend, 8'h20);
        chk("edge_setwins_valid", ib.irq_valid, 0);
        ib.req = '0;
        ib.irq_ack = 1'b0;
        tick();
        chk("edge_regrant_valid", ib.irq_valid, 1);
        chk("edge_regrant_chan", ib.irq_chan, 1);
        ib.irq_ack = 1'b1;
        tick();
        ib.irq_ack = 1'b0;
        chk("edge_final_pend", ib.pend, 0);

        ia.req = bt(10);
        tick();
        ia.req = '0;
        tick();
        chk("rst_pre_valid", ia.irq_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", ia.irq_valid, 0);
        chk("rst_async_bus", ia.irq_bus, 0);
        chk("rst_async_chan", ia.irq_chan, 0);
        chk("rst_async_pend", ia.pend, 0);
        tick();
        tick();
        rst_n = 1'b1;
        ia.irq_ack = 1'b1;
        tick();
        ia.irq_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ack_novalid", ia.irq_valid, 0);
            chk("rst_ack_nopend", ia.pend, 0);
        end

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_hist[k] = '0; m_valid[k] = 1'b0; m_bus[k] = 0; m_chan[k] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            bit [63:0] ra, rb;
            bit [7:0]  ea, eb;
            bit        ka, kb;
            ra = 64'($urandom & $urandom & $urandom) & 64'h7FF_FFFF;
            rb = 64'($urandom & $urandom) & 64'hFF;
            ea = 8'($urandom_range(0, 7));
            eb = 8'($urandom_range(0, 3));
            ka = 1'($urandom_range(0, 1));
            kb = 1'($urandom_range(0, 1));
            ia.req = ra[26:0]; ia.bus_en = ea[2:0]; ia.irq_ack = ka;
            ib.req = rb[7:0];  ib.bus_en = eb[1:0]; ib.irq_ack = kb;
            model_step(0, 9, 3, 1'b0, ra, ea, ka);
            model_step(1, 4, 2, 1'b1, rb, eb, kb);
            tick();
            chk("rnd_a_valid", ia.irq_valid, m_valid[0]);
            chk("rnd_a_pend", ia.pend, m_pend[0]);
            chk("rnd_b_valid", ib.irq_valid, m_valid[1]);
            chk("rnd_b_pend", ib.pend, m_pend[1]);
            if (m_valid[0]) begin
                chk("rnd_a_bus", ia.irq_bus, 64'(m_bus[0]));
                chk("rnd_a_chan", ia.irq_chan, 64'(m_chan[0]));
            end
            if (m_valid[1]) begin
                chk("rnd_b_bus", ib.irq_bus, 64'(m_bus[1]));
                chk("rnd_b_chan", ib.irq_chan, 64'(m_chan[1]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
